// File: rtl/qep_pkg.sv
`timescale 1ns/1ps
// Shared types and default widths for the quadrature position tracker.
// The homing states and the capture snapshot layout live here.
package qep_pkg;

    localparam int POS_W_DEF = 16;
    localparam int REV_W_DEF = 16;
    localparam int PER_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOMED = 2'd2
    } home_state_e;

    typedef struct packed {
        logic [POS_W_DEF-1:0] pos;
        logic [REV_W_DEF-1:0] rev;
        logic [PER_W_DEF-1:0] per;
        logic                 dir;
    } capture_t;

endpackage

// File: rtl/qep_period_timer.sv
`timescale 1ns/1ps
// Edge-to-edge period timer with saturation at PER_MAX and standstill detection.
// o_perNext exposes the value the period register takes at the coming edge.
module qep_period_timer #(
    parameter int          PER_W   = 24,
    parameter int unsigned PER_MAX = 32'h00FF_FFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse,
    output logic [PER_W-1:0] o_perLive,
    output logic [PER_W-1:0] o_perNext,
    output logic             o_standstill
);

    localparam logic [PER_W-1:0] PER_MAX_V = PER_W'(PER_MAX);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_perLive;
    logic             r_standstill;

    logic [PER_W:0]   w_cntInc;
    logic             w_cntAtMax;
    logic [PER_W-1:0] w_cntNext;
    logic [PER_W-1:0] w_perNext;
    logic             w_stillNext;

    // Widened by one bit so cnt+1 cannot overflow when PER_MAX is all ones.
    assign w_cntInc   = {1'b0, r_cnt} + (PER_W+1)'(1);
    assign w_cntAtMax = (w_cntInc >= {1'b0, PER_MAX_V});

    always_comb begin
        w_cntNext   = r_cnt;
        w_perNext   = r_perLive;
        w_stillNext = r_standstill;
        if (pulse) begin
            w_cntNext   = '0;
            w_perNext   = w_cntAtMax ? PER_MAX_V : w_cntInc[PER_W-1:0];
            w_stillNext = 1'b0;
        end else begin
            if (r_cnt < PER_MAX_V) begin
                w_cntNext = w_cntInc[PER_W-1:0];
            end
            if (w_cntAtMax) begin
                w_stillNext = 1'b1;
                w_perNext   = PER_MAX_V;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_perLive    <= '0;
            r_standstill <= 1'b0;
        end else begin
            r_cnt        <= w_cntNext;
            r_perLive    <= w_perNext;
            r_standstill <= w_stillNext;
        end
    end

    assign o_perLive    = r_perLive;
    assign o_perNext    = w_perNext;
    assign o_standstill = r_standstill;

endmodule

// File: rtl/qep_position_tracker.sv
`timescale 1ns/1ps
// Wrapped position / revolution tracker fed by the quadrature decoder strobes,
// with index homing, sticky overspeed error and a coherent snapshot handshake.
module qep_position_tracker
    import qep_pkg::*;
#(
    parameter int          CPR     = 4096,
    parameter int          POS_W   = POS_W_DEF,
    parameter int          REV_W   = REV_W_DEF,
    parameter int          PER_W   = PER_W_DEF,
    parameter int unsigned PER_MAX = 32'h00FF_FFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse,
    input  logic             dir,
    input  logic             qep_overspeed,
    input  logic             index,
    input  logic             home_arm,
    input  logic             zero_clr,
    input  logic             err_clr,
    input  logic             capture_req,
    output logic             capture_ack,
    output logic [POS_W-1:0] pos_snap,
    output logic [REV_W-1:0] rev_snap,
    output logic [PER_W-1:0] per_snap,
    output logic             dir_snap,
    output logic             standstill,
    output logic             homed,
    output logic             err_overspeed
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CPR - 1);

    home_state_e      r_state;
    home_state_e      w_stateNext;

    logic [POS_W-1:0] r_pos;
    logic [REV_W-1:0] r_rev;
    logic             r_dir;
    logic             r_indexD;
    logic             r_err;
    logic             r_ack;
    capture_t         r_snap;

    logic [POS_W-1:0] w_posNext;
    logic [REV_W-1:0] w_revNext;
    logic             w_dirNext;
    logic             w_indexRise;
    logic             w_homeZero;
    logic [PER_W-1:0] w_perLive;
    logic [PER_W-1:0] w_perNext;
    logic             w_standstill;

    qep_period_timer #(
        .PER_W  (PER_W),
        .PER_MAX(PER_MAX)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .pulse       (pulse),
        .o_perLive   (w_perLive),
        .o_perNext   (w_perNext),
        .o_standstill(w_standstill)
    );

    assign w_indexRise = index & ~r_indexD;
    assign w_homeZero  = (r_state == ARMED) && w_indexRise;

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (home_arm)    w_stateNext = ARMED;
            ARMED:   if (w_indexRise) w_stateNext = HOMED;
            HOMED:   if (home_arm)    w_stateNext = ARMED;
            default:                  w_stateNext = IDLE;
        endcase
    end

    // Homing zero outranks software zero, and either one swallows a coincident pulse.
    always_comb begin
        w_posNext = r_pos;
        w_revNext = r_rev;
        if (w_homeZero || zero_clr) begin
            w_posNext = '0;
            w_revNext = '0;
        end else if (pulse) begin
            if (dir) begin
                if (r_pos == POS_LAST) begin
                    w_posNext = '0;
                    w_revNext = r_rev + REV_W'(1);
                end else begin
                    w_posNext = r_pos + POS_W'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    w_posNext = POS_LAST;
                    w_revNext = r_rev - REV_W'(1);
                end else begin
                    w_posNext = r_pos - POS_W'(1);
                end
            end
        end
    end

    assign w_dirNext = pulse ? dir : r_dir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_rev    <= '0;
            r_dir    <= 1'b0;
            r_indexD <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_pos    <= w_posNext;
            r_rev    <= w_revNext;
            r_dir    <= w_dirNext;
            r_indexD <= index;
            if (qep_overspeed) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Snapshot takes the next-state values so an update in the request cycle is included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= '0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= capture_req;
            if (capture_req) begin
                r_snap.pos <= w_posNext;
                r_snap.rev <= w_revNext;
                r_snap.per <= w_perNext;
                r_snap.dir <= w_dirNext;
            end
        end
    end

    assign capture_ack   = r_ack;
    assign pos_snap      = r_snap.pos;
    assign rev_snap      = r_snap.rev;
    assign per_snap      = r_snap.per;
    assign dir_snap      = r_snap.dir;
    assign standstill    = w_standstill;
    assign homed         = (r_state == HOMED);
    assign err_overspeed = r_err;

endmodule

// File: tb/tb_qep_position_tracker.sv
`timescale 1ns/1ps
// Self-checking bench for qep_position_tracker: constant vector table, directed
// corner sequences and a randomized run against an absolute-count reference model.
module tb_qep_position_tracker;

    localparam int CPR     = 4096;
    localparam int PER_MAX = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pulse = 1'b0, dir = 1'b0, qep_overspeed = 1'b0, index = 1'b0;
    logic        home_arm = 1'b0, zero_clr = 1'b0, err_clr = 1'b0, capture_req = 1'b0;
    logic        capture_ack, dir_snap, standstill, homed, err_overspeed;
    logic [15:0] pos_snap, rev_snap;
    logic [23:0] per_snap;

    always #5 clk = ~clk;

    qep_position_tracker #(
        .CPR(CPR), .POS_W(16), .REV_W(16), .PER_W(24), .PER_MAX(PER_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pulse(pulse), .dir(dir),
        .qep_overspeed(qep_overspeed), .index(index), .home_arm(home_arm),
        .zero_clr(zero_clr), .err_clr(err_clr), .capture_req(capture_req),
        .capture_ack(capture_ack), .pos_snap(pos_snap), .rev_snap(rev_snap),
        .per_snap(per_snap), .dir_snap(dir_snap), .standstill(standstill),
        .homed(homed), .err_overspeed(err_overspeed)
    );

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model: position kept as one signed absolute count, period as cycle-index differences.
    longint      mAbs, mK, mLast;
    int          mPer;
    bit          mDir, mStill, mArmed, mHomed, mIdxPrev, mErr, mAck;
    logic [15:0] mSnapPos, mSnapRev;
    logic [23:0] mSnapPer;
    bit          mSnapDir;

    typedef struct {
        bit pulse, dir, ov, errClr, zeroClr, capReq;
        bit expAck;
        int expPos;
        int expRev;
        bit expErr;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [15:0] posOf(longint a);
        longint r;
        r = a % CPR;
        if (r < 0) r += CPR;
        return 16'(r);
    endfunction

    function automatic logic [15:0] revOf(longint a);
        longint r;
        r = a % CPR;
        if (r < 0) r += CPR;
        return 16'((a - r) / CPR);
    endfunction

    function automatic void modelReset();
        mAbs = 0; mK = 0; mLast = -1; mPer = 0;
        mDir = 0; mStill = 0; mArmed = 0; mHomed = 0; mIdxPrev = 0; mErr = 0; mAck = 0;
        mSnapPos = '0; mSnapRev = '0; mSnapPer = '0; mSnapDir = 0;
    endfunction

    function automatic void modelStep();
        bit     rise;
        longint elapsed;
        rise = index && !mIdxPrev;
        mIdxPrev = index;
        if (mArmed && rise) begin
            mAbs = 0; mArmed = 0; mHomed = 1;
        end else begin
            if (zero_clr) mAbs = 0;
            else if (pulse) mAbs += dir ? 1 : -1;
            if (home_arm) begin mArmed = 1; mHomed = 0; end
        end
        if (pulse) mDir = dir;
        elapsed = mK - mLast;
        if (pulse) begin
            mPer = (elapsed > PER_MAX) ? PER_MAX : int'(elapsed);
            mStill = 0;
            mLast = mK;
        end else if (elapsed >= PER_MAX) begin
            mStill = 1;
            mPer = PER_MAX;
        end
        if (qep_overspeed) mErr = 1;
        else if (err_clr) mErr = 0;
        mAck = capture_req;
        if (capture_req) begin
            mSnapPos = posOf(mAbs);
            mSnapRev = revOf(mAbs);
            mSnapPer = 24'(mPer);
            mSnapDir = mDir;
        end
        mK++;
    endfunction

    task automatic checkVal(input string name, input longint act, input longint exp);
        nVectors++;
        if (act != exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("capture_ack", capture_ack, mAck);
        checkVal("pos_snap", pos_snap, mSnapPos);
        checkVal("rev_snap", rev_snap, mSnapRev);
        checkVal("per_snap", per_snap, mSnapPer);
        checkVal("dir_snap", dir_snap, mSnapDir);
        checkVal("standstill", standstill, mStill);
        checkVal("homed", homed, mHomed);
        checkVal("err_overspeed", err_overspeed, mErr);
    endtask

    task automatic applyStimulus(input bit p, input bit d, input bit ov, input bit ec,
                                 input bit zc, input bit cr);
        pulse = p; dir = d; qep_overspeed = ov; err_clr = ec; zero_clr = zc; capture_req = cr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        modelStep();
        checkOutput();
    endtask

    task automatic clearInputs();
        applyStimulus(0, 0, 0, 0, 0, 0);
        index = 0; home_arm = 0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        clearInputs();
        #1;
        modelReset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4095, 'hFFFF, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0,    0,      1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,    0,      1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2,    0,      1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0,    0,      1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4095, 'hFFFF, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4094, 'hFFFF, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4094, 'hFFFF, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4094, 'hFFFF, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4094, 'hFFFF, 1'b1};

        modelReset();
        #2;
        checkVal("reset capture_ack", capture_ack, 0);
        checkVal("reset pos_snap", pos_snap, 0);
        checkVal("reset standstill", standstill, 0);
        checkVal("reset homed", homed, 0);
        doReset();

        // Table: reverse wrap from reset, overspeed/err_clr priority, zero_clr over pulse.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].pulse, tbl[i].dir, tbl[i].ov, tbl[i].errClr,
                          tbl[i].zeroClr, tbl[i].capReq);
            step();
            checkVal($sformatf("tbl%0d ack", i), capture_ack, tbl[i].expAck);
            checkVal($sformatf("tbl%0d pos", i), pos_snap, tbl[i].expPos);
            checkVal($sformatf("tbl%0d rev", i), rev_snap, tbl[i].expRev);
            checkVal($sformatf("tbl%0d err", i), err_overspeed, tbl[i].expErr);
        end
        checkVal("tbl dir_snap after reverse", dir_snap, 0);

        // Forward wrap 4095 -> 0 with rev increment, and ack timing.
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4095; i++) step();
        applyStimulus(1, 1, 0, 0, 0, 0);
        step();
        checkVal("fwd ack before req", capture_ack, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        checkVal("fwd ack", capture_ack, 1);
        checkVal("fwd pos", pos_snap, 0);
        checkVal("fwd rev", rev_snap, 1);
        checkVal("fwd dir", dir_snap, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        checkVal("fwd ack drops", capture_ack, 0);

        // Homing: arm, then index rise coincident with a pulse zeroes; a later rise does not.
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        home_arm = 1;
        step();
        home_arm = 0;
        checkVal("home armed not homed", homed, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        applyStimulus(1, 1, 0, 0, 0, 1);
        index = 1;
        step();
        checkVal("home homed", homed, 1);
        checkVal("home pos", pos_snap, 0);
        checkVal("home rev", rev_snap, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        index = 0;
        step();
        applyStimulus(1, 1, 0, 0, 0, 1);
        index = 1;
        step();
        checkVal("home no rezero pos", pos_snap, 2);
        checkVal("home still homed", homed, 1);
        index = 0;

        // Period: 50-cycle spacing, then standstill at PER_MAX, then cleared by a pulse.
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        step();
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 49; i++) step();
            applyStimulus(1, 1, 0, 0, 0, 1);
            step();
            checkVal("period 50", per_snap, 50);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 999; i++) step();
        checkVal("standstill not yet", standstill, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        checkVal("standstill set", standstill, 1);
        checkVal("standstill per", per_snap, PER_MAX);
        applyStimulus(1, 0, 0, 0, 0, 1);
        step();
        checkVal("standstill cleared", standstill, 0);
        checkVal("per saturated", per_snap, PER_MAX);

        // Reset while an ack is in flight.
        applyStimulus(1, 1, 0, 0, 0, 0);
        home_arm = 1;
        step();
        home_arm = 0;
        applyStimulus(0, 0, 1, 0, 0, 1);
        step();
        checkVal("pre-reset ack", capture_ack, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkVal("midreset ack", capture_ack, 0);
        checkVal("midreset rev", rev_snap, 0);
        checkVal("midreset per", per_snap, 0);
        checkVal("midreset err", err_overspeed, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        index = 1;
        applyStimulus(1, 1, 0, 0, 0, 1);
        step();
        checkVal("after reset FSM idle", homed, 0);
        index = 0;

        // Randomized run against the model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99) < 50, $urandom_range(99) < 60,
                          $urandom_range(99) < 2, $urandom_range(99) < 5,
                          $urandom_range(99) < 2, $urandom_range(99) < 30);
            home_arm = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 10) index = ~index;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/qep_position_tracker.md
Name: qep_position_tracker

Overview:
- Sits directly downstream of the quadrature edge decoder.
- Consumes its per-edge `pulse`/`dir` strobes and its overspeed flag, and maintains a wrapped mechanical position, a revolution count and an edge-to-edge period measurement.
- Provides index-based homing and a coherent snapshot handshake, so the motor-control/Avalon CSR side reads consistent data.

Parameters:
- CPR, 4096: quadrature counts per revolution (x4 decoded); position range 0..CPR-1.
- POS_W, 16: position width; must satisfy 2^POS_W >= CPR.
- REV_W, 16: signed revolution counter width.
- PER_W, 24: period counter width.
- PER_MAX, 2^24-1: standstill timeout in clk cycles; must be <= 2^PER_W-1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pulse  in  1  one-cycle edge strobe from decoder
- dir  in  1  direction qualifying pulse (1 = forward)
- qep_overspeed  in  1  decoder overspeed strobe
- index  in  1  Z channel, already synchronised to clk
- home_arm  in  1  one-cycle request to home on next index rising edge
- zero_clr  in  1  one-cycle software zero of position and rev count
- err_clr  in  1  clears sticky error
- capture_req  in  1  snapshot request
- capture_ack  out  1  one-cycle acknowledge; snapshot valid
- pos_snap  out  POS_W  captured position
- rev_snap  out  REV_W  captured signed revolution count
- per_snap  out  PER_W  captured period (cycles between last two edges)
- dir_snap  out  1  captured last direction
- standstill  out  1  live: no edge for PER_MAX cycles
- homed  out  1  live: homing completed
- err_overspeed  out  1  sticky overspeed error

Behaviour:
- Reset: all outputs and internal registers are 0. Homing FSM enters IDLE. The period counter is 0.
- Position update applies on a cycle with pulse=1.
  - dir=1: pos+1. If pos==CPR-1 it wraps to 0 and rev+1.
  - dir=0: pos-1. If pos==0 it wraps to CPR-1 and rev-1.
  - rev wraps two's-complement silently.
  - Update is visible internally on the next cycle.
- Priority per cycle, highest first: homing zero (FSM ARMED and index rising edge) > zero_clr > pulse. A pulse coinciding with either zero is discarded, leaving pos=0 and rev=0.
- Index edge: detected with a 1-cycle registered copy; rising edge = index & ~index_d.
- Homing FSM:
  - IDLE --home_arm--> ARMED; clears `homed`.
  - ARMED --index rising--> HOMED; zeroes pos and rev; `homed`=1.
  - HOMED --home_arm--> ARMED.
  - home_arm while ARMED keeps ARMED.
  - zero_clr does not change FSM state.
- Period measurement:
  - cnt increments each cycle and saturates at PER_MAX.
  - On pulse: per_live <= cnt+1 (saturated at PER_MAX), cnt <= 0, standstill <= 0.
  - When cnt reaches PER_MAX: standstill <= 1 and per_live <= PER_MAX.
  - The first pulse after reset reports the cycles since reset, saturated.
  - A direction change does not reset the measurement.
- dir_live is updated on every pulse.
- Overspeed:
  - err_overspeed is set on any qep_overspeed=1 and held until err_clr.
  - Set wins over a simultaneous err_clr.
  - Counting continues during error.
- Capture handshake:
  - capture_req sampled high in cycle N: snapshot registers load the live pos/rev/per/dir as of the end of cycle N, including any pulse update in N. capture_ack=1 in cycle N+1 for exactly one cycle.
  - Snapshot outputs hold until the next capture.
  - capture_req held high captures every cycle and asserts ack every cycle.
- Reset mid-operation: everything returns asynchronously to reset values. An in-flight capture_ack is dropped.

Decomposition:
- Package qep_pkg holds:
  - the homing state enum: IDLE, ARMED, HOMED;
  - width/localparam defaults for POS_W, REV_W, PER_W;
  - a capture struct {pos, rev, per, dir}.
- One sub-module, qep_period_timer, contains the saturating cnt, per_live and standstill logic. Its inputs are pulse, clk and reset_n.
- Position, homing FSM, error and capture logic live in the top module.

Test Plan:
- Forward wrap: CPR=4096, from pos=4095, rev=0, one pulse with dir=1, then capture → pos_snap=0, rev_snap=1, dir_snap=1, ack one cycle after req.
- Reverse wrap: from reset, one pulse with dir=0, then capture → pos_snap=4095, rev_snap=-1 (0xFFFF), dir_snap=0.
- Homing:
  - 100 forward pulses, then home_arm, then 5 more pulses, then index rise coincident with a pulse → pos=0, rev=0, homed=1.
  - A subsequent index rise does not re-zero.
- Period:
  - Pulses spaced 50 cycles apart → per_snap=50.
  - Then no pulses with PER_MAX=1000 → standstill=1 at cnt=1000, per_snap=1000.
  - The next pulse clears standstill.
- Overspeed: qep_overspeed strobe coincident with err_clr → err_overspeed=1. err_clr alone next cycle → 0. Position keeps counting throughout.
- Reset mid-capture: capture_req in cycle N, reset_n low in N+1 → capture_ack=0, all snapshots 0, FSM IDLE, homed=0.
